// File: rtl/cpu_pkg.sv
// Shared constants and types for the 14-bit CPU fetch/sequencing logic.
package cpu_pkg;
   localparam int PC_W        = 11;
   localparam int INSTR_W     = 14;
   localparam int STACK_DEPTH = 8;
   localparam int SP_W        = $clog2(STACK_DEPTH);

   localparam logic [INSTR_W-1:0] INSTR_NOP = 14'h0000;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2
   } fetch_state_t;

   // Wraps naturally at 2^PC_W.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + 11'd1;
   endfunction
endpackage

// File: rtl/instr_fetch_seq_call_stack.sv
// Circular return-address stack: overflow overwrites the oldest entry,
// underflow reads the slot below the write pointer; both raise sticky flags.
module call_stack
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top,
   output logic            ovf,
   output logic            unf
);
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam logic [CNT_W-1:0] SP_FULL = CNT_W'(STACK_DEPTH);
   localparam logic [CNT_W-1:0] SP_ONE  = CNT_W'(1);
   localparam logic [SP_W-1:0]  WP_ONE  = SP_W'(1);

   logic [PC_W-1:0]  mem_r [STACK_DEPTH];
   logic [SP_W-1:0]  wp_r;
   logic [CNT_W-1:0] sp_r;
   logic             ovf_r;
   logic             unf_r;
   logic             full_s;
   logic             empty_s;

   assign full_s  = (sp_r == SP_FULL);
   assign empty_s = (sp_r == {CNT_W{1'b0}});
   assign top     = mem_r[wp_r - WP_ONE];
   assign ovf     = ovf_r;
   assign unf     = unf_r;

   // Pointer, occupancy, storage and sticky error flags; pop wins over push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            mem_r[i] <= {PC_W{1'b0}};
         end
         wp_r  <= {SP_W{1'b0}};
         sp_r  <= {CNT_W{1'b0}};
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else if (pop) begin
         wp_r <= wp_r - WP_ONE;
         if (empty_s) begin
            unf_r <= 1'b1;
         end else begin
            sp_r <= sp_r - SP_ONE;
         end
      end else if (push) begin
         mem_r[wp_r] <= push_data;
         wp_r        <= wp_r + WP_ONE;
         if (full_s) begin
            ovf_r <= 1'b1;
         end else begin
            sp_r <= sp_r + SP_ONE;
         end
      end else begin
         wp_r <= wp_r;
         sp_r <= sp_r;
      end
   end
endmodule

// File: rtl/instr_fetch_seq.sv
// FETCH -> DECODE -> EXEC sequencer owning the pc, the instruction register
// and the call stack; redirects are honoured only in an unstalled EXEC.
module instr_fetch_seq
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    rom_addr_out,
   input  logic [INSTR_W-1:0] rom_data_in,
   output logic [INSTR_W-1:0] ir_out,
   output logic [1:0]         phase_out,
   output logic               ir_valid,
   output logic [PC_W-1:0]    pc_out,
   input  logic               stall,
   input  logic               pc_load,
   input  logic [PC_W-1:0]    pc_load_addr,
   input  logic               stack_push,
   input  logic               stack_pop,
   input  logic               skip,
   output logic               stack_ovf,
   output logic               stack_unf
);
   fetch_state_t       state_r;
   logic [PC_W-1:0]    pc_r;
   logic [INSTR_W-1:0] ir_r;
   logic               ir_valid_r;
   logic               exec_go_s;
   logic               push_s;
   logic               pop_s;
   logic [PC_W-1:0]    stack_top_s;

   // Stack strobes: pop overrides every other redirect in the same EXEC.
   always_comb begin
      exec_go_s = (state_r == S_EXEC) && !stall;
      pop_s     = exec_go_s && stack_pop;
      push_s    = exec_go_s && !stack_pop && stack_push;
   end

   call_stack u_call_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (pc_r),
      .top       (stack_top_s),
      .ovf       (stack_ovf),
      .unf       (stack_unf)
   );

   assign rom_addr_out = pc_r;
   assign pc_out       = pc_r;
   assign ir_out       = ir_r;
   assign phase_out    = state_r;
   assign ir_valid     = ir_valid_r;

   // Sequencer FSM with pc, IR and ir_valid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_FETCH;
         pc_r       <= {PC_W{1'b0}};
         ir_r       <= INSTR_NOP;
         ir_valid_r <= 1'b0;
      end else begin
         case (state_r)
            S_FETCH: begin
               ir_r       <= rom_data_in;
               pc_r       <= pc_inc(pc_r);
               ir_valid_r <= 1'b1;
               state_r    <= S_DECODE;
            end
            S_DECODE: begin
               state_r <= S_EXEC;
            end
            S_EXEC: begin
               if (!stall) begin
                  ir_valid_r <= 1'b0;
                  state_r    <= S_FETCH;
                  // A push without a load only saves the return address.
                  if (stack_pop) begin
                     pc_r <= stack_top_s;
                  end else if (pc_load) begin
                     pc_r <= pc_load_addr;
                  end else if (skip && !stack_push) begin
                     pc_r <= pc_inc(pc_r);
                  end else begin
                     pc_r <= pc_r;
                  end
               end else begin
                  state_r <= S_EXEC;
               end
            end
            default: begin
               state_r    <= S_FETCH;
               ir_valid_r <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Randomized scoreboard bench: a behavioural model predicts every cycle's
// outputs, a separate monitor compares them on the falling edge.
`timescale 1ns/1ps
module tb_instr_fetch_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] rom_addr_out;
   logic [13:0] rom_data_in;
   logic [13:0] ir_out;
   logic [1:0]  phase_out;
   logic        ir_valid;
   logic [10:0] pc_out;
   logic        stall, pc_load, stack_push, stack_pop, skip;
   logic [10:0] pc_load_addr;
   logic        stack_ovf, stack_unf;

   instr_fetch_seq dut (
      .clk(clk), .rst_n(rst_n), .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
      .ir_out(ir_out), .phase_out(phase_out), .ir_valid(ir_valid), .pc_out(pc_out),
      .stall(stall), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
      .stack_push(stack_push), .stack_pop(stack_pop), .skip(skip),
      .stack_ovf(stack_ovf), .stack_unf(stack_unf)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] rom_word(input logic [10:0] a);
      logic [31:0] x;
      if (a == 11'd0) return 14'h3004;
      x = {21'd0, a} * 32'd2654435761;
      return x[29:16];
   endfunction

   assign rom_data_in = rom_word(rom_addr_out);

   typedef struct {
      int ph; int pc; int ir; int v; int ovf; int unf;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   // Reference model state: architectural view of the sequencer.
   int m_ph, m_pc, m_ir, m_wp, m_cnt, m_ovf, m_unf;
   int m_stk[8];
   int ic = 0;
   bit new_exec = 1'b0;
   bit did_rst = 1'b0;
   int rst_hold = 3;
   bit c_pop, c_load, c_push, c_skip;
   logic [10:0] c_addr;

   task automatic model_clock();
      exp_t e;
      if (!rst_n) begin
         m_ph = 0; m_pc = 0; m_ir = 0; m_wp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
         for (int i = 0; i < 8; i++) m_stk[i] = 0;
         new_exec = 1'b0;
      end else if (m_ph == 0) begin
         m_ir = rom_word(11'(m_pc));
         m_pc = (m_pc + 1) % 2048;
         m_ph = 1;
      end else if (m_ph == 1) begin
         m_ph = 2;
         new_exec = 1'b1;
      end else if (!stall) begin
         if (stack_pop) begin
            if (m_cnt == 0) m_unf = 1; else m_cnt--;
            m_wp = (m_wp + 7) % 8;
            m_pc = m_stk[m_wp];
         end else begin
            if (stack_push) begin
               m_stk[m_wp] = m_pc;
               m_wp = (m_wp + 1) % 8;
               if (m_cnt == 8) m_ovf = 1; else m_cnt++;
            end
            if (pc_load) m_pc = int'(pc_load_addr);
            else if (skip && !stack_push) m_pc = (m_pc + 1) % 2048;
         end
         m_ph = 0;
         ic++;
      end
      e.ph = m_ph; e.pc = m_pc; e.ir = m_ir; e.v = (m_ph != 0) ? 1 : 0;
      e.ovf = m_ovf; e.unf = m_unf;
      sb_q.push_back(e);
   endtask

   task automatic choose_cmd();
      int r;
      c_pop = 0; c_load = 0; c_push = 0; c_skip = 0;
      c_addr = 11'($urandom_range(0, 2047));
      if (ic < 20) begin
      end else if (ic < 30) begin
         c_load = 1; c_push = 1;
      end else if (ic < 40) begin
         c_pop = 1; c_load = 1'($urandom); c_push = 1'($urandom); c_skip = 1'($urandom);
      end else if (ic == 40) begin
         c_load = 1; c_addr = 11'h7FD;
      end else if (ic < 46) begin
      end else if (ic == 46) begin
         c_skip = 1;
      end else if (ic == 47) begin
         c_push = 1; c_skip = 1;
      end else begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1: begin c_load = 1; c_push = 1'($urandom); c_skip = 1'($urandom); end
            2: begin c_pop = 1; c_load = 1'($urandom); c_skip = 1'($urandom); end
            3, 4: c_skip = 1;
            5: c_push = 1;
            default: begin end
         endcase
         if ($urandom_range(0, 7) == 0) c_addr = 11'h7FF;
      end
   endtask

   task automatic drive_garbage();
      pc_load      = 1'($urandom);
      stack_push   = 1'($urandom);
      stack_pop    = 1'($urandom);
      skip         = 1'($urandom);
      pc_load_addr = 11'($urandom);
   endtask

   task automatic step();
      @(negedge clk);
      if (rst_hold > 0) begin
         rst_hold--;
         if (rst_hold == 0) begin
            #2 rst_n = 1'b1;
         end
      end else if (m_ph == 2) begin
         if (new_exec) begin
            choose_cmd();
            new_exec = 1'b0;
         end
         stall = (ic >= 41) && ($urandom_range(0, 3) == 0);
         if (stall) begin
            drive_garbage();
         end else begin
            pc_load = c_load; stack_push = c_push; stack_pop = c_pop;
            skip = c_skip; pc_load_addr = c_addr;
         end
         // Asynchronous reset in the middle of an EXEC cycle.
         if (ic >= 300 && !did_rst) begin
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_pc", 32'(pc_out), 32'd0);
            chk("async_rst_ir", 32'(ir_out), 32'd0);
            chk("async_rst_phase", 32'(phase_out), 32'd0);
            chk("async_rst_valid", 32'(ir_valid), 32'd0);
            did_rst = 1'b1;
            rst_hold = 2;
         end
      end else begin
         stall = 1'($urandom);
         drive_garbage();
      end
      @(posedge clk);
      model_clock();
   endtask

   // Monitor: one expected record per cycle, compared away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (sb_q.size() == 0) begin
               chk("sb_underrun", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("phase_out", 32'(phase_out), 32'(e.ph));
               chk("pc_out", 32'(pc_out), 32'(e.pc));
               chk("rom_addr_out", 32'(rom_addr_out), 32'(e.pc));
               chk("ir_out", 32'(ir_out), 32'(e.ir));
               chk("ir_valid", 32'(ir_valid), 32'(e.v));
               chk("stack_ovf", 32'(stack_ovf), 32'(e.ovf));
               chk("stack_unf", 32'(stack_unf), 32'(e.unf));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; pc_load = 1'b0; stack_push = 1'b0;
      stack_pop = 1'b0; skip = 1'b0; pc_load_addr = 11'd0;
      #1;
      chk("reset_pc", 32'(pc_out), 32'd0);
      chk("reset_ir", 32'(ir_out), 32'd0);
      chk("reset_phase", 32'(phase_out), 32'd0);
      chk("reset_valid", 32'(ir_valid), 32'd0);
      chk("reset_ovf", 32'(stack_ovf), 32'd0);
      chk("reset_unf", 32'(stack_unf), 32'd0);
      step();
      mon_en = 1'b1;
      while (ic < 700) step();
      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
